// File: rtl/y86_execute_stage_if.sv
// Decode-to-execute bundle: decoded operands and pipeline control in, registered
// execute results and condition codes out.
interface y86_execute_stage_if;
  logic               stall;
  logic               bubble;
  logic               in_valid;
  logic [3:0]         icode;
  logic [3:0]         ifun;
  logic signed [63:0] valA;
  logic signed [63:0] valB;
  logic signed [63:0] valC;
  logic [3:0]         dstE;
  logic               out_valid;
  logic [3:0]         out_icode;
  logic signed [63:0] out_valE;
  logic signed [63:0] out_valA;
  logic [3:0]         out_dstE;
  logic               out_cnd;
  logic               out_err;
  logic               zf;
  logic               sf;
  logic               of;

  modport master (
    output stall, bubble, in_valid, icode, ifun, valA, valB, valC, dstE,
    input  out_valid, out_icode, out_valE, out_valA, out_dstE, out_cnd, out_err, zf, sf, of
  );

  modport slave (
    input  stall, bubble, in_valid, icode, ifun, valA, valB, valC, dstE,
    output out_valid, out_icode, out_valE, out_valA, out_dstE, out_cnd, out_err, zf, sf, of
  );
endinterface

// File: rtl/y86_execute_stage.sv
// Y86-64 execute stage: ALU operand select, 64-bit ALU, condition-code register
// and jXX/cmov condition evaluation, with all results registered for memory.
module y86_execute_stage (
  input logic                clk,
  input logic                reset,
  y86_execute_stage_if.slave ex
);
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_RRMOV = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;
  localparam logic [3:0] R_NONE  = 4'hF;

  function automatic logic signed [63:0] alu(input logic [1:0] fn,
                                             input logic signed [63:0] a,
                                             input logic signed [63:0] b);
    case (fn)
      2'd0:    alu = b + a;
      2'd1:    alu = b - a;
      2'd2:    alu = b & a;
      default: alu = b ^ a;
    endcase
  endfunction

  // Two's-complement overflow judged from operand and result sign bits.
  function automatic logic ovf(input logic [1:0] fn, input logic a_s,
                               input logic b_s, input logic r_s);
    case (fn)
      2'd0:    ovf = (a_s == b_s) && (r_s != b_s);
      2'd1:    ovf = (a_s != b_s) && (r_s != b_s);
      default: ovf = 1'b0;
    endcase
  endfunction

  function automatic logic cond(input logic [3:0] fn, input logic z,
                                input logic s, input logic o);
    case (fn)
      4'd0:    cond = 1'b1;
      4'd1:    cond = (s ^ o) | z;
      4'd2:    cond = s ^ o;
      4'd3:    cond = z;
      4'd4:    cond = !z;
      4'd5:    cond = !(s ^ o);
      4'd6:    cond = !(s ^ o) && !z;
      default: cond = 1'b0;
    endcase
  endfunction

  logic signed [63:0] alu_a_p0, alu_b_p0, vale_p0;
  logic [1:0]         fn_p0;
  logic               use_alu_p0, err_p0, set_cc_p0, cnd_p0, of_n_p0;
  logic [3:0]         dste_p0;

  logic               vld_p1, cnd_p1, err_p1, zf_p1, sf_p1, of_p1;
  logic [3:0]         icode_p1, dste_p1;
  logic signed [63:0] vale_p1, vala_p1;

  // ---- p0: operand select, ALU, condition evaluation against current CC ----
  always_comb begin
    alu_a_p0   = '0;
    alu_b_p0   = '0;
    fn_p0      = 2'd0;
    use_alu_p0 = 1'b1;
    err_p0     = 1'b0;
    case (ex.icode)
      I_RRMOV:          alu_a_p0 = ex.valA;
      I_IRMOV:          alu_a_p0 = ex.valC;
      I_RMMOV, I_MRMOV: begin
        alu_a_p0 = ex.valC;
        alu_b_p0 = ex.valB;
      end
      I_OPQ: begin
        if (ex.ifun > 4'd3) begin
          err_p0     = 1'b1;
          use_alu_p0 = 1'b0;
        end else begin
          alu_a_p0 = ex.valA;
          alu_b_p0 = ex.valB;
          fn_p0    = ex.ifun[1:0];
        end
      end
      I_CALL, I_PUSH: begin
        alu_a_p0 = -64'sd8;
        alu_b_p0 = ex.valB;
      end
      I_RET, I_POP: begin
        alu_a_p0 = 64'sd8;
        alu_b_p0 = ex.valB;
      end
      default:          use_alu_p0 = 1'b0;
    endcase
    vale_p0   = use_alu_p0 ? alu(fn_p0, alu_a_p0, alu_b_p0) : '0;
    set_cc_p0 = (ex.icode == I_OPQ) && !err_p0;
    of_n_p0   = ovf(fn_p0, alu_a_p0[63], alu_b_p0[63], vale_p0[63]);
    cnd_p0    = ((ex.icode == I_RRMOV) || (ex.icode == I_JXX)) ?
                cond(ex.ifun, zf_p1, sf_p1, of_p1) : 1'b0;
    dste_p0   = ((ex.icode == I_RRMOV) && !cnd_p0) ? R_NONE : ex.dstE;
  end

  // ---- p1: output registers and condition codes ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      icode_p1 <= I_NOP;
      vale_p1  <= '0;
      vala_p1  <= '0;
      dste_p1  <= R_NONE;
      cnd_p1   <= 1'b0;
      err_p1   <= 1'b0;
      zf_p1    <= 1'b1;
      sf_p1    <= 1'b0;
      of_p1    <= 1'b0;
    end else if (!ex.stall) begin
      if (ex.bubble || !ex.in_valid) begin
        vld_p1   <= 1'b0;
        icode_p1 <= I_NOP;
        vale_p1  <= '0;
        vala_p1  <= '0;
        dste_p1  <= R_NONE;
        cnd_p1   <= 1'b0;
        err_p1   <= 1'b0;
      end else begin
        vld_p1   <= 1'b1;
        icode_p1 <= ex.icode;
        vale_p1  <= vale_p0;
        vala_p1  <= ex.valA;
        dste_p1  <= dste_p0;
        cnd_p1   <= cnd_p0;
        err_p1   <= err_p0;
        if (set_cc_p0) begin
          zf_p1 <= (vale_p0 == 64'sd0);
          sf_p1 <= vale_p0[63];
          of_p1 <= of_n_p0;
        end
      end
    end
  end

  assign ex.out_valid = vld_p1;
  assign ex.out_icode = icode_p1;
  assign ex.out_valE  = vale_p1;
  assign ex.out_valA  = vala_p1;
  assign ex.out_dstE  = dste_p1;
  assign ex.out_cnd   = cnd_p1;
  assign ex.out_err   = err_p1;
  assign ex.zf        = zf_p1;
  assign ex.sf        = sf_p1;
  assign ex.of        = of_p1;
endmodule

// File: doc/y86_execute_stage.md
# y86_execute_stage

Registered execute stage of the Y86-64 pipeline. It sits directly downstream of decode and consumes decoded operands. It selects ALU operands, computes valE with the 64-bit add/sub/and/xor datapath (the same ALU primitives as the and64 unit), maintains the condition-code register (ZF/SF/OF) and evaluates the branch/cmov condition. All outputs are registered; the memory stage consumes them one cycle later.

## Interface
- No parameters; data width fixed at 64.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold all output registers and CC
- bubble  in  1  load a nop into the output registers
- in_valid  in  1  decode fields below are meaningful this cycle
- icode  in  4  instruction code
- ifun  in  4  function code
- valA  in  64  operand A (signed)
- valB  in  64  operand B (signed)
- valC  in  64  immediate/displacement (signed)
- dstE  in  4  destination register for valE; 0xF = none
- out_valid  out  1  registered in_valid
- out_icode  out  4  registered icode
- out_valE  out  64  ALU result
- out_valA  out  64  valA passed through
- out_dstE  out  4  dstE, forced to 0xF on a not-taken cmov
- out_cnd  out  1  condition result for icode 2 and icode 7
- out_err  out  1  OPq with ifun > 3
- zf, sf, of  out  1 each  current CC register contents

## Operation
- ALU operand selection (A, B):
  - icode 2 rrmovq/cmov: A = valA, B = 0, add.
  - icode 3 irmovq: A = valC, B = 0, add.
  - icode 4/5 rmmovq/mrmovq: A = valC, B = valB, add.
  - icode 6 OPq: A = valA, B = valB, function = ifun.
  - icode 8/0xA call/push: A = -8, B = valB, add.
  - icode 9/0xB ret/pop: A = +8, B = valB, add.
  - Any other icode: valE = 0.
- ALU functions:
  - 0 add: B + A
  - 1 sub: B − A
  - 2 and: B & A
  - 3 xor: B ^ A
  - Results wrap modulo 2^64.
  - OPq with ifun > 3: valE = 0, out_err = 1, CC not updated.
- CC update on an OPq (ifun ≤ 3) when in_valid=1, stall=0, bubble=0:
  - ZF = (valE == 0)
  - SF = valE[63]
  - OF for add: A[63]==B[63] && valE[63]!=B[63]
  - OF for sub: A[63]!=B[63] && valE[63]!=B[63]
  - OF for and/xor: 0
- Condition evaluation uses the CC register value present before this cycle's edge. Codes by ifun:
  - 0: 1
  - 1 le: (SF^OF)|ZF
  - 2 l: SF^OF
  - 3 e: ZF
  - 4 ne: !ZF
  - 5 ge: !(SF^OF)
  - 6 g: !(SF^OF)&!ZF
  - 7–F: 0
  - cnd = 0 for icodes other than 2 and 7.
- out_dstE:
  - 0xF when icode=2 and cnd=0.
  - 0xF when in_valid=0.
  - Otherwise dstE.
- Register-load priority:
  - reset over stall over bubble over normal load.
  - stall with bubble: stall wins; hold everything.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the out_* ports after edge N.
- CC is updated at the same edge. An OPq followed back-to-back by a jXX/cmov sees the updated CC.
- Reset and bubble load values:
  - out_valid=0
  - out_icode=0x1 (nop)
  - out_valE=0, out_valA=0
  - out_dstE=0xF
  - out_cnd=0, out_err=0
- Reset only, CC: zf=1, sf=0, of=0. Bubble leaves CC unchanged.
- Reset asserted mid-stream discards the in-flight instruction at that edge. The first instruction after reset deasserts is processed normally.
- in_valid=0 with no stall or bubble: load the bubble values; CC unchanged.

## Test plan
- Reset, then hold 2 cycles -> out_icode=1, out_dstE=F, zf=1, sf=0, of=0, out_valid=0.
- OPq and (icode 6, ifun 2), valA=0xB, valB=0x4 -> out_valE=0, zf=1, sf=0, of=0. Then valB=0xC -> out_valE=0x8, zf=0.
- OPq add, valA=valB=0x7FFFFFFFFFFFFFFF -> out_valE=0xFFFFFFFFFFFFFFFE, sf=1, of=1. OPq sub, valB=0x8000000000000000, valA=1 -> valE=0x7FFFFFFFFFFFFFFF, of=1.
- OPq sub valB=5, valA=5, next cycle cmovne (icode 2, ifun 4) dstE=3 -> out_cnd=0, out_dstE=F. The following jle (icode 7, ifun 1) -> out_cnd=1.
- push (icode A), valB=0x100 -> out_valE=0xF8, CC unchanged. pop (icode B), valB=0xF8 -> out_valE=0x100.
- stall for 3 cycles during an OPq -> outputs and CC held. bubble+stall -> held. bubble alone -> nop loaded, CC unchanged. OPq ifun 5 -> out_err=1, out_valE=0, CC unchanged.
